// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA timing generator: default 640x480@60 timing,
// derived line/frame totals, coordinate and RGB565 types, and the pipeline
// stage records used by vga_timing_gen.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  // Default 640x480 timing (pixel clock ~25.2 MHz).
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF); // 800
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF); // 525

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [15:0]        rgb565_t;

  // Stage 1: the pixel request plus the sync decode for the same (h,v).
  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
    logic   frame_start;
    logic   line_start;
    logic   hsync_n;
    logic   vsync_n;
  } req_stage_t;

  // Stage 2: control delayed while the pixel source answers the request.
  typedef struct packed {
    logic valid;
    logic hsync_n;
    logic vsync_n;
  } ctl_stage_t;

  localparam req_stage_t REQ_STAGE_RST = '{valid: 1'b0, x: '0, y: '0,
                                           frame_start: 1'b0, line_start: 1'b0,
                                           hsync_n: 1'b1, vsync_n: 1'b1};
  localparam ctl_stage_t CTL_STAGE_RST = '{valid: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Wrap counter for one display axis (pixels of a line, or lines of a frame),
// with terminal-count, active-region and sync-window decode.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous return to 0 (has priority over advance)
//   advance    : count one step; wraps to 0 after ACTIVE+FP+SYNC+BP-1
//   count      : current position
//   active     : count is inside the visible region
//   sync_n     : active-low sync, low for ACTIVE+FP .. ACTIVE+FP+SYNC-1
//   last       : count is at the terminal value
// -----------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clear,
  input  logic   advance,
  output coord_t count,
  output logic   active,
  output logic   sync_n,
  output logic   last
);

  localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam coord_t      LAST_C     = coord_t'(TOTAL - 1);
  localparam coord_t      ACTIVE_C   = coord_t'(ACTIVE);
  localparam coord_t      SYNC_FIRST = coord_t'(ACTIVE + FP);
  localparam coord_t      SYNC_LAST  = coord_t'(ACTIVE + FP + SYNC - 1);

  coord_t count_q, count_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (advance) begin
      count_d = last ? '0 : count_q + coord_t'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count  = count_q;
  assign last   = (count_q == LAST_C);
  assign active = (count_q < ACTIVE_C);
  assign sync_n = !((count_q >= SYNC_FIRST) && (count_q <= SYNC_LAST));

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing with a pixel-fetch request port. Each raster position
// (h,v) is issued as a request; the pixel source answers one cycle later and
// the pixel, together with hsync/vsync/de for that position, leaves two cycles
// after the request.
//   clk, reset_n : pixel clock, asynchronous active-low reset
//   en           : run enable; low restarts the raster and flushes the pipe
//   req_valid, req_x, req_y : pixel fetch request (coords hold when idle)
//   frame_start  : with request (0,0);  line_start : with request (0,y)
//   rgb_in       : RGB565 answer, valid exactly one cycle after req_valid
//   hsync, vsync : active-low syncs;  de : display enable
//   rgb_out      : pixel to the encoder, forced to 0 while de=0
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    en,
  output logic    req_valid,
  output coord_t  req_x,
  output coord_t  req_y,
  output logic    frame_start,
  output logic    line_start,
  input  rgb565_t rgb_in,
  output logic    hsync,
  output logic    vsync,
  output logic    de,
  output rgb565_t rgb_out
);

  // run_q delays the start by one edge after reset release or en rising, so
  // the first request (0,0) always lands on the second edge with en high.
  logic       run_q, run_d;
  coord_t     h_count, v_count;
  logic       h_active, v_active, h_sync_n, v_sync_n, h_last;
  logic       v_last_unused;

  req_stage_t req_q, req_d;
  ctl_stage_t ctl_q, ctl_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  rgb565_t    rgb_q, rgb_d;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
  ) u_h_counter (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear   (!en),
    .advance (run_q),
    .count   (h_count),
    .active  (h_active),
    .sync_n  (h_sync_n),
    .last    (h_last)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
  ) u_v_counter (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear   (!en),
    .advance (run_q && h_last),
    .count   (v_count),
    .active  (v_active),
    .sync_n  (v_sync_n),
    .last    (v_last_unused)
  );

  assign run_d = en;

  // Stage 1: request for the current (h,v). Coordinates hold through blanking.
  always_comb begin
    req_d             = req_q;
    req_d.valid       = 1'b0;
    req_d.frame_start = 1'b0;
    req_d.line_start  = 1'b0;
    req_d.hsync_n     = 1'b1;
    req_d.vsync_n     = 1'b1;
    if (!en) begin
      req_d = REQ_STAGE_RST;
    end else if (run_q) begin
      req_d.valid   = h_active && v_active;
      req_d.hsync_n = h_sync_n;
      req_d.vsync_n = v_sync_n;
      if (h_active && v_active) begin
        req_d.x           = h_count;
        req_d.y           = v_count;
        req_d.line_start  = (h_count == '0);
        req_d.frame_start = (h_count == '0) && (v_count == '0);
      end
    end
  end

  // Stage 2: control waits one cycle while the source produces the pixel.
  always_comb begin
    ctl_d = CTL_STAGE_RST;
    if (en) begin
      ctl_d = '{valid: req_q.valid, hsync_n: req_q.hsync_n, vsync_n: req_q.vsync_n};
    end
  end

  // Stage 3: rgb_in is captured here on the edge that closes its valid cycle,
  // so pixel and syncs for one position leave together.
  always_comb begin
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    de_d    = 1'b0;
    rgb_d   = '0;
    if (en) begin
      hsync_d = ctl_q.hsync_n;
      vsync_d = ctl_q.vsync_n;
      de_d    = ctl_q.valid;
      if (ctl_q.valid) rgb_d = rgb_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      req_q   <= REQ_STAGE_RST;
      ctl_q   <= CTL_STAGE_RST;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      run_q   <= run_d;
      req_q   <= req_d;
      ctl_q   <= ctl_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
    end
  end

  assign req_valid   = req_q.valid;
  assign req_x       = req_q.x;
  assign req_y       = req_q.y;
  assign frame_start = req_q.frame_start;
  assign line_start  = req_q.line_start;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen using a reduced raster (56x19 clocks) so
// whole frames fit in a short run. A reference model walks the raster; the
// expected pixel/sync output of each request is queued and compared when it
// leaves the pipeline two cycles later. The pixel source answers each request
// with {y[5:0], x[9:0]} one cycle later and 16'hFFFF otherwise.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int HA = 40, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;   // 56
  localparam int VT = VA + VFP + VS + VBP;   // 19
  localparam int FRAME = HT * VT;            // 1064

  logic    clk = 1'b0;
  logic    reset_n, en;
  logic    req_valid, frame_start, line_start, hsync, vsync, de;
  coord_t  req_x, req_y;
  rgb565_t rgb_in, rgb_out;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .frame_start (frame_start),
    .line_start  (line_start),
    .rgb_in      (rgb_in),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb_out     (rgb_out)
  );

  typedef struct packed {
    logic    hsync;
    logic    vsync;
    logic    de;
    rgb565_t rgb;
  } out_t;

  localparam out_t OUT_RST = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, rgb: 16'h0000};

  int     checks = 0;
  int     failures = 0;
  out_t   sb_q[$];
  int     n_pix;
  bit     run_m;
  coord_t last_x, last_y;
  bit     prev_v;
  coord_t prev_x, prev_y;
  int     cyc = 0;

  // Measurements taken from the outputs.
  int fs_total = 0, fs_cyc = 0, fs_first = -1;
  int frame_period = -1, frame_de = -1, frame_ls = -1, frame_vs = -1;
  int de_acc = 0, ls_acc = 0, vs_acc = 0;
  int first_de_rise = -1, last_de0 = -1, hs_fall = -1, hs_rise = -1;
  bit prev_de = 1'b0, prev_hs = 1'b1;
  bit found;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run_m  = 1'b0;
    n_pix  = 0;
    last_x = '0;
    last_y = '0;
    prev_v = 1'b0;
    prev_x = '0;
    prev_y = '0;
    sb_q.delete();
    sb_q.push_back(OUT_RST);
    sb_q.push_back(OUT_RST);
  endtask

  // One clock: advance the model, compare request and output ports, then
  // answer the previous cycle's request on rgb_in.
  task automatic step();
    logic en_s;
    int   h, v;
    bit   valid;
    out_t exp_o, ent;
    en_s  = en;
    @(posedge clk);
    #1;
    cyc++;
    ent   = OUT_RST;
    valid = 1'b0;
    h     = 0;
    v     = 0;
    if (!en_s) begin
      run_m  = 1'b0;
      n_pix  = 0;
      last_x = '0;
      last_y = '0;
      sb_q.delete();
      sb_q.push_back(OUT_RST);
      exp_o = OUT_RST;
    end else begin
      exp_o = sb_q.pop_front();
      if (!run_m) begin
        run_m = 1'b1;
      end else begin
        h = n_pix % HT;
        v = (n_pix / HT) % VT;
        n_pix++;
        valid = (h < HA) && (v < VA);
        if (valid) begin
          last_x = coord_t'(h);
          last_y = coord_t'(v);
        end
        ent.hsync = !((h >= HA + HFP) && (h < HA + HFP + HS));
        ent.vsync = !((v >= VA + VFP) && (v < VA + VFP + VS));
        ent.de    = valid;
        ent.rgb   = valid ? {last_y[5:0], last_x} : 16'h0000;
      end
    end
    sb_q.push_back(ent);

    check("req_valid",   req_valid,   valid);
    check("req_x",       req_x,       last_x);
    check("req_y",       req_y,       last_y);
    check("frame_start", frame_start, valid && h == 0 && v == 0);
    check("line_start",  line_start,  valid && h == 0);
    check("hsync",       hsync,       exp_o.hsync);
    check("vsync",       vsync,       exp_o.vsync);
    check("de",          de,          exp_o.de);
    check("rgb_out",     rgb_out,     exp_o.rgb);

    if (frame_start) begin
      fs_total++;
      if (fs_first < 0) fs_first = cyc;
      if (fs_total > 1) begin
        frame_period = cyc - fs_cyc;
        frame_de     = de_acc;
        frame_ls     = ls_acc;
        frame_vs     = vs_acc;
      end
      fs_cyc = cyc;
      de_acc = 0;
      ls_acc = 0;
      vs_acc = 0;
    end
    if (de)         de_acc++;
    if (line_start) ls_acc++;
    if (!vsync)     vs_acc++;
    if (de && !prev_de && first_de_rise < 0)              first_de_rise = cyc;
    if (!de && prev_de && last_de0 < 0)                   last_de0 = cyc - 1;
    if (!hsync && prev_hs && hs_fall < 0)                 hs_fall = cyc;
    if (hsync && !prev_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = cyc;
    prev_de = de;
    prev_hs = hsync;

    rgb_in = prev_v ? {prev_y[5:0], prev_x} : 16'hFFFF;
    prev_v = req_valid;
    prev_x = req_x;
    prev_y = req_y;
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b1;
    rgb_in  = 16'hFFFF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid",   req_valid,   1'b0);
    check("rst_req_x",       req_x,       10'd0);
    check("rst_req_y",       req_y,       10'd0);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_line_start",  line_start,  1'b0);
    check("rst_hsync",       hsync,       1'b1);
    check("rst_vsync",       vsync,       1'b1);
    check("rst_de",          de,          1'b0);
    check("rst_rgb_out",     rgb_out,     16'h0000);

    // Release: first request (0,0) on the second edge.
    reset_n = 1'b1;
    step();
    check("release_edge1_fs", frame_start, 1'b0);
    step();
    check("release_edge2_fs", frame_start, 1'b1);

    // Two full frames of raster.
    for (int i = 0; i < 3 * FRAME && fs_total < 2; i++) step();
    check("two_frame_starts",   fs_total,              2);
    check("frame_period",       frame_period,          FRAME);
    check("frame_de_cycles",    frame_de,              HA * VA);
    check("frame_line_starts",  frame_ls,              VA);
    check("frame_vsync_low",    frame_vs,              VS * HT);
    check("first_de_latency",   first_de_rise - fs_first, 2);
    check("line0_de_cycles",    last_de0 - first_de_rise + 1, HA);
    check("line0_hsync_offset", hs_fall - last_de0,    HFP + 1);
    check("line0_hsync_width",  hs_rise - hs_fall,     HS);

    // Drop en mid-frame at (30,5) for 5 cycles.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      found = req_valid && req_x == 10'd30 && req_y == 10'd5;
    end
    check("reach_h30_v5", found, 1'b1);
    check("pre_drop_de", de, 1'b1);
    en = 1'b0;
    step();
    check("drop_req_valid", req_valid, 1'b0);
    check("drop_req_x",     req_x,     10'd0);
    check("drop_hsync",     hsync,     1'b1);
    check("drop_vsync",     vsync,     1'b1);
    check("drop_de",        de,        1'b0);
    check("drop_rgb_out",   rgb_out,   16'h0000);
    repeat (4) step();
    en = 1'b1;
    step();
    check("restart_edge1_fs", frame_start, 1'b0);
    step();
    check("restart_edge2_fs", frame_start, 1'b1);
    check("restart_req_x",    req_x,       10'd0);
    check("restart_req_y",    req_y,       10'd0);

    // Asynchronous reset during active video.
    repeat (10) step();
    check("pre_reset_de", de, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check("async_active_de",        de,        1'b0);
    check("async_active_rgb_out",   rgb_out,   16'h0000);
    check("async_active_hsync",     hsync,     1'b1);
    check("async_active_req_valid", req_valid, 1'b0);
    #1 reset_n = 1'b1;
    model_reset();
    step();
    step();
    check("rerelease_edge2_fs", frame_start, 1'b1);

    // Asynchronous reset inside the hsync pulse.
    found = 1'b0;
    for (int i = 0; i < 2 * HT && !found; i++) begin
      step();
      found = !hsync;
    end
    check("reach_hsync_low", found, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check("async_sync_hsync",   hsync,   1'b1);
    check("async_sync_vsync",   vsync,   1'b1);
    check("async_sync_de",      de,      1'b0);
    check("async_sync_rgb_out", rgb_out, 16'h0000);
    #1 reset_n = 1'b1;
    model_reset();
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
